// File: rtl/csr_defs.sv
//------------------------------------------------------------------------------
// Module      : csr_defs (package)
// Description : CSR numbers, exception codes and field positions shared by the
//               CSR register file and its timer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package csr_defs;

  // CSR numbers
  localparam logic [13:0] CSR_CRMD      = 14'h000;
  localparam logic [13:0] CSR_PRMD      = 14'h001;
  localparam logic [13:0] CSR_ECFG      = 14'h004;
  localparam logic [13:0] CSR_ESTAT     = 14'h005;
  localparam logic [13:0] CSR_ERA       = 14'h006;
  localparam logic [13:0] CSR_BADV      = 14'h007;
  localparam logic [13:0] CSR_EENTRY    = 14'h00C;
  localparam logic [13:0] CSR_SAVE0     = 14'h030;
  localparam logic [13:0] CSR_SAVE1     = 14'h031;
  localparam logic [13:0] CSR_SAVE2     = 14'h032;
  localparam logic [13:0] CSR_SAVE3     = 14'h033;
  localparam logic [13:0] CSR_TID       = 14'h040;
  localparam logic [13:0] CSR_TCFG      = 14'h041;
  localparam logic [13:0] CSR_TVAL      = 14'h042;
  localparam logic [13:0] CSR_TICLR     = 14'h044;
  localparam logic [13:0] CSR_TLBRENTRY = 14'h088;

  // Exception codes, same encodings as the WB stage
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
  localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

  // Field positions
  localparam int CRMD_IE       = 2;
  localparam int CRMD_DA       = 3;
  localparam int CRMD_PG       = 4;
  localparam int PRMD_PIE      = 2;
  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;
  localparam int IS_TIMER      = 11;
  localparam int IS_IPI        = 12;

  // Software-writable bits of each CSR
  localparam logic [31:0] CRMD_WMASK  = 32'h0000_01FF;
  localparam logic [31:0] PRMD_WMASK  = 32'h0000_0007;
  localparam logic [31:0] ECFG_WMASK  = 32'h0000_1BFF;
  localparam logic [31:0] ESTAT_WMASK = 32'h0000_0003;
  localparam logic [31:0] ENTRY_WMASK = 32'hFFFF_FFC0;

  localparam logic [31:0] CRMD_RESET  = 32'h0000_0008;

  // Masked field update used by every software write
  function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                            input logic [31:0] wmask,
                                            input logic [31:0] wvalue);
    return (wmask & wvalue) | (~wmask & old_val);
  endfunction

  // Exceptions that record the faulting data address in BADV
  function automatic logic badv_takes_addr(input logic [5:0] ecode,
                                           input logic [8:0] esubcode);
    return (ecode == ECODE_TLBR) || (ecode == ECODE_PIL) || (ecode == ECODE_PIS) ||
           (ecode == ECODE_PIF)  || (ecode == ECODE_PME) || (ecode == ECODE_PPI) ||
           (ecode == ECODE_ALE)  ||
           ((ecode == ECODE_ADE) && (esubcode == ESUBCODE_ADEM));
  endfunction

endpackage

`default_nettype wire

// File: rtl/csr_timer.sv
//------------------------------------------------------------------------------
// Module      : csr_timer
// Description : TCFG/TVAL stable timer: loads on enable, counts down, reloads
//               in periodic mode and freezes at all-ones in one-shot mode.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module csr_timer
  import csr_defs::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wmask,
  input  logic [31:0] tcfg_wvalue,
  output logic [31:0] tcfg,
  output logic [31:0] tval,
  output logic        expire
);

  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] w_tcfg_new;

  // Next TCFG/TVAL: a write that leaves the timer enabled restarts it outright
  always_comb begin
    w_tcfg_new = csr_merge(tcfg_q, tcfg_wmask, tcfg_wvalue);
    tcfg_d     = tcfg_we ? w_tcfg_new : tcfg_q;
    tval_d     = tval_q;
    if (tcfg_we && w_tcfg_new[TCFG_EN]) begin
      tval_d = {w_tcfg_new[31:2], 2'b00};
    end else if (tcfg_q[TCFG_EN] && (tval_q != 32'hFFFF_FFFF)) begin
      if ((tval_q == 32'h0) && tcfg_q[TCFG_PERIODIC]) begin
        tval_d = {tcfg_q[31:2], 2'b00};
      end else begin
        // 0 wraps to all-ones, which then holds a one-shot timer
        tval_d = tval_q - 32'h1;
      end
    end
  end

  // Timer state registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tcfg_q <= 32'h0;
      tval_q <= 32'hFFFF_FFFF;
    end else begin
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
    end
  end

  assign tcfg   = tcfg_q;
  assign tval   = tval_q;
  assign expire = tcfg_q[TCFG_EN] && (tval_q == 32'h0);

endmodule

`default_nettype wire

// File: rtl/csr_regfile.sv
//------------------------------------------------------------------------------
// Module      : csr_regfile
// Description : Control/status register file: software CSR access, exception
//               and ertn commit, interrupt status and stable timer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module csr_regfile
  import csr_defs::*;
#(
  parameter logic [31:0] COREID = 32'h0
)(
  input  logic        clk,
  input  logic        resetn,
  input  logic [13:0] rd_num,
  output logic [31:0] rd_value,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badvaddr,
  input  logic        ertn_flush,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_entry,
  output logic        has_int,
  output logic [1:0]  crmd_plv,
  output logic [1:0]  crmd_da_pg
);

  logic [31:0] crmd_q, crmd_d;
  logic [31:0] prmd_q, prmd_d;
  logic [31:0] ecfg_q, ecfg_d;
  logic [31:0] estat_q, estat_d;
  logic [31:0] era_q, era_d;
  logic [31:0] badv_q, badv_d;
  logic [31:0] eentry_q, eentry_d;
  logic [31:0] tlbrentry_q, tlbrentry_d;
  logic [31:0] tid_q, tid_d;
  logic [31:0] save_q [4];
  logic [31:0] save_d [4];

  logic        w_sw_we;
  logic        w_ticlr;
  logic        w_timer_expire;
  logic [31:0] w_tcfg;
  logic [31:0] w_tval;

  csr_timer u_timer (
    .clk         (clk),
    .resetn      (resetn),
    .tcfg_we     (csr_we && (csr_num == CSR_TCFG)),
    .tcfg_wmask  (csr_wmask),
    .tcfg_wvalue (csr_wvalue),
    .tcfg        (w_tcfg),
    .tval        (w_tval),
    .expire      (w_timer_expire)
  );

  // Next-state for all CSRs: exception beats ertn beats software write
  always_comb begin
    w_sw_we     = csr_we && !wb_ex && !ertn_flush;
    w_ticlr     = csr_we && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];

    crmd_d      = crmd_q;
    prmd_d      = prmd_q;
    ecfg_d      = ecfg_q;
    estat_d     = estat_q;
    era_d       = era_q;
    badv_d      = badv_q;
    eentry_d    = eentry_q;
    tlbrentry_d = tlbrentry_q;
    tid_d       = tid_q;
    for (int i = 0; i < 4; i++) begin
      save_d[i] = save_q[i];
    end

    if (wb_ex) begin
      prmd_d[1:0]      = crmd_q[1:0];
      prmd_d[PRMD_PIE] = crmd_q[CRMD_IE];
      crmd_d[1:0]      = 2'b00;
      crmd_d[CRMD_IE]  = 1'b0;
      if (wb_ecode == ECODE_TLBR) begin
        crmd_d[CRMD_DA] = 1'b1;
        crmd_d[CRMD_PG] = 1'b0;
      end
      era_d           = wb_pc;
      estat_d[21:16]  = wb_ecode;
      estat_d[30:22]  = wb_esubcode;
      if (badv_takes_addr(wb_ecode, wb_esubcode)) begin
        badv_d = wb_badvaddr;
      end else if ((wb_ecode == ECODE_ADE) && (wb_esubcode == ESUBCODE_ADEF)) begin
        badv_d = wb_pc;
      end
    end else if (ertn_flush) begin
      crmd_d[1:0]     = prmd_q[1:0];
      crmd_d[CRMD_IE] = prmd_q[PRMD_PIE];
      if (estat_q[21:16] == ECODE_TLBR) begin
        crmd_d[CRMD_DA] = 1'b0;
        crmd_d[CRMD_PG] = 1'b1;
      end
    end else if (w_sw_we) begin
      case (csr_num)
        CSR_CRMD:  crmd_d  = csr_merge(crmd_q,  csr_wmask & CRMD_WMASK,  csr_wvalue);
        CSR_PRMD:  prmd_d  = csr_merge(prmd_q,  csr_wmask & PRMD_WMASK,  csr_wvalue);
        CSR_ESTAT: estat_d = csr_merge(estat_q, csr_wmask & ESTAT_WMASK, csr_wvalue);
        CSR_ERA:   era_d   = csr_merge(era_q,   csr_wmask, csr_wvalue);
        CSR_BADV:  badv_d  = csr_merge(badv_q,  csr_wmask, csr_wvalue);
        default: ;
      endcase
    end

    // CSRs not touched by commits take software writes unconditionally
    if (csr_we) begin
      case (csr_num)
        CSR_ECFG:      ecfg_d      = csr_merge(ecfg_q, csr_wmask & ECFG_WMASK, csr_wvalue);
        CSR_EENTRY:    eentry_d    = csr_merge(eentry_q, csr_wmask & ENTRY_WMASK, csr_wvalue);
        CSR_TLBRENTRY: tlbrentry_d = csr_merge(tlbrentry_q, csr_wmask & ENTRY_WMASK, csr_wvalue);
        CSR_TID:       tid_d       = csr_merge(tid_q, csr_wmask, csr_wvalue);
        CSR_SAVE0:     save_d[0]   = csr_merge(save_q[0], csr_wmask, csr_wvalue);
        CSR_SAVE1:     save_d[1]   = csr_merge(save_q[1], csr_wmask, csr_wvalue);
        CSR_SAVE2:     save_d[2]   = csr_merge(save_q[2], csr_wmask, csr_wvalue);
        CSR_SAVE3:     save_d[3]   = csr_merge(save_q[3], csr_wmask, csr_wvalue);
        default: ;
      endcase
    end

    // Interrupt lines are resampled every cycle; timer set wins over clear
    estat_d[9:2]   = hw_int_in;
    estat_d[IS_IPI] = ipi_int_in;
    if (w_ticlr) begin
      estat_d[IS_TIMER] = 1'b0;
    end
    if (w_timer_expire) begin
      estat_d[IS_TIMER] = 1'b1;
    end
  end

  // CSR state registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      crmd_q      <= CRMD_RESET;
      prmd_q      <= 32'h0;
      ecfg_q      <= 32'h0;
      estat_q     <= 32'h0;
      era_q       <= 32'h0;
      badv_q      <= 32'h0;
      eentry_q    <= 32'h0;
      tlbrentry_q <= 32'h0;
      tid_q       <= COREID;
      for (int i = 0; i < 4; i++) begin
        save_q[i] <= 32'h0;
      end
    end else begin
      crmd_q      <= crmd_d;
      prmd_q      <= prmd_d;
      ecfg_q      <= ecfg_d;
      estat_q     <= estat_d;
      era_q       <= era_d;
      badv_q      <= badv_d;
      eentry_q    <= eentry_d;
      tlbrentry_q <= tlbrentry_d;
      tid_q       <= tid_d;
      for (int i = 0; i < 4; i++) begin
        save_q[i] <= save_d[i];
      end
    end
  end

  // Combinational read port; unimplemented numbers and TICLR read as zero
  always_comb begin
    rd_value = 32'h0;
    case (rd_num)
      CSR_CRMD:      rd_value = crmd_q;
      CSR_PRMD:      rd_value = prmd_q;
      CSR_ECFG:      rd_value = ecfg_q;
      CSR_ESTAT:     rd_value = estat_q;
      CSR_ERA:       rd_value = era_q;
      CSR_BADV:      rd_value = badv_q;
      CSR_EENTRY:    rd_value = eentry_q;
      CSR_SAVE0:     rd_value = save_q[0];
      CSR_SAVE1:     rd_value = save_q[1];
      CSR_SAVE2:     rd_value = save_q[2];
      CSR_SAVE3:     rd_value = save_q[3];
      CSR_TID:       rd_value = tid_q;
      CSR_TCFG:      rd_value = w_tcfg;
      CSR_TVAL:      rd_value = w_tval;
      CSR_TLBRENTRY: rd_value = tlbrentry_q;
      default:       rd_value = 32'h0;
    endcase
  end

  assign ex_entry   = (wb_ecode == ECODE_TLBR) ? tlbrentry_q : eentry_q;
  assign ertn_entry = era_q;
  assign has_int    = crmd_q[CRMD_IE] && (|(estat_q[12:0] & ecfg_q[12:0]));
  assign crmd_plv   = crmd_q[1:0];
  assign crmd_da_pg = {crmd_q[CRMD_DA], crmd_q[CRMD_PG]};

endmodule

`default_nettype wire

// File: tb/tb_csr_regfile.sv
//------------------------------------------------------------------------------
// Module      : tb_csr_regfile
// Description : Self-checking bench for csr_regfile.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_csr_regfile;

  localparam logic [31:0] COREID = 32'h0000_0A5A;
  localparam logic [31:0] ALL    = 32'hFFFF_FFFF;
  localparam int SEL_RD = 0, SEL_EX = 1, SEL_ERTN = 2, SEL_INT = 3, SEL_PLV = 4, SEL_DAPG = 5;

  logic        clk = 1'b0;
  logic        resetn;
  logic [13:0] rd_num;
  logic [31:0] rd_value;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_badvaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry, ertn_entry;
  logic        has_int;
  logic [1:0]  crmd_plv, crmd_da_pg;

  always #50 clk = ~clk;

  csr_regfile #(.COREID(COREID)) dut (
    .clk(clk), .resetn(resetn), .rd_num(rd_num), .rd_value(rd_value),
    .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .wb_badvaddr(wb_badvaddr), .ertn_flush(ertn_flush), .hw_int_in(hw_int_in),
    .ipi_int_in(ipi_int_in), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
    .has_int(has_int), .crmd_plv(crmd_plv), .crmd_da_pg(crmd_da_pg)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    string       name;
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] val;
    logic [31:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vt[16];
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string name, input int sel, input logic [13:0] num,
                          input logic [31:0] mask, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.sel = sel; e.num = num; e.mask = mask; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_num = e.num;
      #1;
      case (e.sel)
        SEL_RD:   act = rd_value;
        SEL_EX:   act = ex_entry;
        SEL_ERTN: act = ertn_entry;
        SEL_INT:  act = {31'b0, has_int};
        SEL_PLV:  act = {30'b0, crmd_plv};
        default:  act = {30'b0, crmd_da_pg};
      endcase
      checks++;
      if ((act & e.mask) !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act & e.mask, e.exp);
      end
    end
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_num = num; csr_wmask = mask; csr_wvalue = val; csr_we = 1'b1;
    step();
    csr_we = 1'b0;
  endtask

  function automatic vec_t mk(input string n, input logic [13:0] num, input logic [31:0] mask,
                              input logic [31:0] val, input logic [31:0] exp);
    vec_t v;
    v.name = n; v.num = num; v.mask = mask; v.val = val; v.exp = exp;
    return v;
  endfunction

  task automatic check_reset(input string tag);
    expect_v({tag, "_crmd"},  SEL_RD, 14'h000, ALL, 32'h0000_0008);
    expect_v({tag, "_tval"},  SEL_RD, 14'h042, ALL, 32'hFFFF_FFFF);
    expect_v({tag, "_tid"},   SEL_RD, 14'h040, ALL, COREID);
    expect_v({tag, "_era"},   SEL_RD, 14'h006, ALL, 32'h0);
    expect_v({tag, "_estat"}, SEL_RD, 14'h005, ALL, 32'h0);
    expect_v({tag, "_int"},   SEL_INT, 14'h0, ALL, 32'h0);
    expect_v({tag, "_plv"},   SEL_PLV, 14'h0, ALL, 32'h0);
    expect_v({tag, "_dapg"},  SEL_DAPG, 14'h0, ALL, 32'h2);
    drain();
  endtask

  initial begin
    resetn = 1'b0; rd_num = '0; csr_we = 1'b0; csr_num = '0; csr_wmask = '0; csr_wvalue = '0;
    wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; wb_badvaddr = '0;
    ertn_flush = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;

    // reset state
    step(); step();
    resetn = 1'b1;
    check_reset("reset");

    // software write table: write, then read back next cycle
    vt[0]  = mk("crmd_all",   14'h000, ALL, ALL, 32'h0000_01FF);
    vt[1]  = mk("prmd_all",   14'h001, ALL, ALL, 32'h0000_0007);
    vt[2]  = mk("ecfg_all",   14'h004, ALL, ALL, 32'h0000_1BFF);
    vt[3]  = mk("estat_all",  14'h005, ALL, ALL, 32'h0000_0003);
    vt[4]  = mk("era",        14'h006, ALL, 32'h1234_5678, 32'h1234_5678);
    vt[5]  = mk("badv",       14'h007, ALL, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    vt[6]  = mk("eentry",     14'h00C, ALL, ALL, 32'hFFFF_FFC0);
    vt[7]  = mk("tlbrentry",  14'h088, ALL, 32'h1C00_00FF, 32'h1C00_00C0);
    vt[8]  = mk("save0",      14'h030, ALL, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    vt[9]  = mk("save3",      14'h033, ALL, 32'hCAFE_F00D, 32'hCAFE_F00D);
    vt[10] = mk("tid_masked", 14'h040, 32'h0000_FFFF, 32'hABCD_1234, 32'h0000_1234);
    vt[11] = mk("tval_ro",    14'h042, ALL, 32'h0, 32'hFFFF_FFFF);
    vt[12] = mk("ticlr_rd0",  14'h044, ALL, ALL, 32'h0);
    vt[13] = mk("unimpl",     14'h002, ALL, ALL, 32'h0);
    vt[14] = mk("crmd_mask",  14'h000, 32'h0000_0003, 32'h0, 32'h0000_01FC);
    vt[15] = mk("prmd_mask",  14'h001, 32'h0000_0004, 32'h0, 32'h0000_0003);
    for (int i = 0; i < 16; i++) begin
      wr(vt[i].num, vt[i].mask, vt[i].val);
      expect_v(vt[i].name, SEL_RD, vt[i].num, ALL, vt[i].exp);
      drain();
    end
    expect_v("tbl_has_int", SEL_INT, 14'h0, ALL, 32'h1);
    expect_v("tbl_dapg", SEL_DAPG, 14'h0, ALL, 32'h3);
    drain();

    // reset mid-operation with an exception pending
    resetn = 1'b0; wb_ex = 1'b1; wb_ecode = 6'h3F; wb_pc = 32'h1234;
    step();
    wb_ex = 1'b0; resetn = 1'b1;
    check_reset("midrst");

    // exception then ertn; same-cycle read sees the old value
    wr(14'h00C, ALL, 32'h1C00_8000);
    csr_num = 14'h000; csr_wmask = ALL; csr_wvalue = 32'hF; csr_we = 1'b1;
    expect_v("crmd_old", SEL_RD, 14'h000, ALL, 32'h8);
    drain();
    step(); csr_we = 1'b0;
    expect_v("crmd_new", SEL_RD, 14'h000, ALL, 32'hF);
    drain();
    wb_ex = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0100; wb_badvaddr = 32'hDEAD_0000;
    expect_v("ex_entry_sys", SEL_EX, 14'h0, ALL, 32'h1C00_8000);
    drain();
    step(); wb_ex = 1'b0;
    expect_v("sys_prmd", SEL_RD, 14'h001, ALL, 32'h7);
    expect_v("sys_crmd", SEL_RD, 14'h000, ALL, 32'h8);
    expect_v("sys_era", SEL_RD, 14'h006, ALL, 32'h1C00_0100);
    expect_v("sys_ecode", SEL_RD, 14'h005, 32'h003F_0000, 32'h000B_0000);
    expect_v("sys_badv", SEL_RD, 14'h007, ALL, 32'h0);
    drain();
    ertn_flush = 1'b1;
    step(); ertn_flush = 1'b0;
    expect_v("ertn_crmd", SEL_RD, 14'h000, ALL, 32'hF);
    expect_v("ertn_entry", SEL_ERTN, 14'h0, ALL, 32'h1C00_0100);
    expect_v("ertn_plv", SEL_PLV, 14'h0, ALL, 32'h3);
    drain();

    // periodic timer, InitVal=4
    wr(14'h004, 32'h800, 32'h800);
    wr(14'h041, ALL, 32'h13);
    for (int k = 0; k <= 17; k++) begin
      expect_v($sformatf("per_tval_%0d", k), SEL_RD, 14'h042, ALL, (k <= 16) ? 32'(16 - k) : 32'd16);
      if (k == 16) begin
        expect_v("per_is11_pre", SEL_RD, 14'h005, 32'h800, 32'h0);
        expect_v("per_int_pre", SEL_INT, 14'h0, ALL, 32'h0);
      end
      if (k == 17) begin
        expect_v("per_is11", SEL_RD, 14'h005, 32'h800, 32'h800);
        expect_v("per_int", SEL_INT, 14'h0, ALL, 32'h1);
      end
      drain();
      if (k < 17) step();
    end
    wr(14'h044, 32'h1, 32'h1);
    expect_v("ticlr_is11", SEL_RD, 14'h005, 32'h800, 32'h0);
    expect_v("ticlr_int", SEL_INT, 14'h0, ALL, 32'h0);
    drain();
    repeat (15) step();
    expect_v("per_tval_0b", SEL_RD, 14'h042, ALL, 32'h0);
    drain();
    wr(14'h044, 32'h1, 32'h1);
    expect_v("set_over_clr", SEL_RD, 14'h005, 32'h800, 32'h800);
    expect_v("per_reload", SEL_RD, 14'h042, ALL, 32'd16);
    drain();

    // one-shot timer, InitVal=2
    wr(14'h041, ALL, 32'h9);
    wr(14'h044, 32'h1, 32'h1);
    for (int k = 1; k <= 12; k++) begin
      expect_v($sformatf("os_tval_%0d", k), SEL_RD, 14'h042, ALL, (k <= 8) ? 32'(8 - k) : 32'hFFFF_FFFF);
      expect_v($sformatf("os_is11_%0d", k), SEL_RD, 14'h005, 32'h800, (k == 9) ? 32'h800 : 32'h0);
      drain();
      if (k == 9) wr(14'h044, 32'h1, 32'h1);
      else step();
    end

    // exception beats a same-cycle software write; BADV selection
    wb_ex = 1'b1; wb_ecode = 6'h09; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0200; wb_badvaddr = 32'h1000_0003;
    csr_we = 1'b1; csr_num = 14'h006; csr_wmask = ALL; csr_wvalue = 32'h55;
    step(); wb_ex = 1'b0; csr_we = 1'b0;
    expect_v("ale_badv", SEL_RD, 14'h007, ALL, 32'h1000_0003);
    expect_v("ale_era", SEL_RD, 14'h006, ALL, 32'h1C00_0200);
    expect_v("ale_ecode", SEL_RD, 14'h005, 32'h003F_0000, 32'h0009_0000);
    drain();
    wb_ex = 1'b1; wb_ecode = 6'h08; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0300; wb_badvaddr = 32'h0BAD;
    step(); wb_ex = 1'b0;
    expect_v("adef_badv", SEL_RD, 14'h007, ALL, 32'h1C00_0300);
    expect_v("adef_estat", SEL_RD, 14'h005, 32'h7FFF_0000, 32'h0008_0000);
    drain();
    wb_ex = 1'b1; wb_ecode = 6'h08; wb_esubcode = 9'h1; wb_pc = 32'h1C00_0304; wb_badvaddr = 32'h2004;
    step(); wb_ex = 1'b0;
    expect_v("adem_badv", SEL_RD, 14'h007, ALL, 32'h2004);
    expect_v("adem_estat", SEL_RD, 14'h005, 32'h7FFF_0000, 32'h0048_0000);
    drain();

    // TLB refill exception and return
    wr(14'h088, ALL, 32'h1C00_1000);
    wr(14'h000, ALL, 32'h13);
    wb_ex = 1'b1; wb_ecode = 6'h3F; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0400;
    expect_v("tlbr_entry", SEL_EX, 14'h0, ALL, 32'h1C00_1000);
    drain();
    step(); wb_ex = 1'b0;
    expect_v("tlbr_dapg", SEL_DAPG, 14'h0, ALL, 32'h2);
    expect_v("tlbr_plv", SEL_PLV, 14'h0, ALL, 32'h0);
    expect_v("tlbr_prmd", SEL_RD, 14'h001, ALL, 32'h3);
    drain();
    ertn_flush = 1'b1;
    step(); ertn_flush = 1'b0;
    expect_v("tlbr_ertn_dapg", SEL_DAPG, 14'h0, ALL, 32'h1);
    expect_v("tlbr_ertn_plv", SEL_PLV, 14'h0, ALL, 32'h3);
    drain();

    // interrupt line sampling
    hw_int_in = 8'h81; ipi_int_in = 1'b1;
    step();
    expect_v("is_sample", SEL_RD, 14'h005, 32'h1FFC, 32'h1204);
    drain();
    wr(14'h000, 32'h4, 32'h4);
    expect_v("int_unmasked_off", SEL_INT, 14'h0, ALL, 32'h0);
    drain();
    wr(14'h004, 32'h1000, 32'h1000);
    expect_v("int_ipi", SEL_INT, 14'h0, ALL, 32'h1);
    drain();
    hw_int_in = 8'h0; ipi_int_in = 1'b0;
    step();
    expect_v("int_drop", SEL_INT, 14'h0, ALL, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
